apb_irq_ctrl: RTL and testbench

APB_IRQ_CTRL -- requirements
Module: apb_irq_ctrl

---
 rtl/apb_irq_ctrl_pkg.sv | 14 +
 rtl/irq_prio_enc.sv | 22 ++
 rtl/apb_irq_ctrl.sv | 139 +++++++++++++
 tb/tb_apb_irq_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_irq_ctrl_pkg.sv
// Shared register map, event-index type and LOST counter width for apb_irq_ctrl.
package apb_irq_ctrl_pkg;

    localparam logic [2:0] REG_PENDING = 3'd0;
    localparam logic [2:0] REG_MASK    = 3'd1;
    localparam logic [2:0] REG_SET     = 3'd2;
    localparam logic [2:0] REG_ID      = 3'd3;
    localparam logic [2:0] REG_LOST    = 3'd4;

    localparam int LOST_W = 16;

    typedef logic [4:0] evt_idx_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the enabled pending vector; purely combinational.
module irq_prio_enc
    import apb_irq_ctrl_pkg::*;
#(
    parameter int NUM_EVENTS = 8
) (
    input  logic [NUM_EVENTS-1:0] i_vec,
    output evt_idx_t              o_idx,
    output logic                  o_vld
);

    // Scan downwards so the last hit, the lowest set index, is the one kept.
    always_comb begin
        o_idx = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = 5'(i);
        end
    end

    assign o_vld = |i_vec;

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: edge-captured pending bits, mask, lowest-index ID, zero-wait-state APB.
// Defining IRQ_LOST_COUNT_EN adds a saturating 16-bit counter of edges coalesced into a pending bit.
module apb_irq_ctrl
    import apb_irq_ctrl_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_EVENTS     = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_EVENTS-1:0]     event_i,
    input  logic                      irq_ack_i,
    input  logic [4:0]                irq_ack_id_i,
    output logic                      irq_o,
    output logic [4:0]                irq_id_o
);

    logic [NUM_EVENTS-1:0] r_event_q;
    logic [NUM_EVENTS-1:0] r_pending;
    logic [NUM_EVENTS-1:0] r_mask;
    logic                  r_armed;

    logic                  w_wr;
    logic                  w_rd;
    logic [2:0]            w_idx;
    logic [NUM_EVENTS-1:0] w_wdat;
    logic [NUM_EVENTS-1:0] w_edge;
    logic [31:0]           w_ack_oh32;
    logic [NUM_EVENTS-1:0] w_ack_oh;
    logic [NUM_EVENTS-1:0] w_set;
    logic [NUM_EVENTS-1:0] w_clr;
    logic [NUM_EVENTS-1:0] w_pending_nxt;
    logic [NUM_EVENTS-1:0] w_active;
    evt_idx_t              w_id;
    logic                  w_vld;
    logic                  w_unused;

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    assign w_wr   = PSEL & PENABLE & PWRITE;
    assign w_rd   = PSEL & PENABLE & ~PWRITE;
    assign w_idx  = PADDR[4:2];
    assign w_wdat = PWDATA[NUM_EVENTS-1:0];

    // r_armed masks the first cycle after reset so a source held high through release is not an edge.
    assign w_edge = event_i & ~r_event_q & {NUM_EVENTS{r_armed}};

    // Out-of-range ack ids shift past the implemented bits and are dropped by the slice.
    assign w_ack_oh32 = irq_ack_i ? (32'd1 << irq_ack_id_i) : 32'd0;
    assign w_ack_oh   = w_ack_oh32[NUM_EVENTS-1:0];

    assign w_set = w_edge   | ((w_wr && w_idx == REG_SET)     ? w_wdat : '0);
    assign w_clr = w_ack_oh | ((w_wr && w_idx == REG_PENDING) ? w_wdat : '0);
    assign w_pending_nxt = (r_pending & ~w_clr) | w_set;
    assign w_active      = r_pending & r_mask;

    assign w_unused = ^{PADDR, PWDATA, w_ack_oh32};

    irq_prio_enc #(
        .NUM_EVENTS (NUM_EVENTS)
    ) u_prio_enc (
        .i_vec (w_active),
        .o_idx (w_id),
        .o_vld (w_vld)
    );

    assign irq_o    = w_vld;
    assign irq_id_o = w_id;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_event_q <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_event_q <= event_i;
            r_pending <= w_pending_nxt;
            r_armed   <= 1'b1;
            if (w_wr && w_idx == REG_MASK) r_mask <= w_wdat;
        end
    end

`ifdef IRQ_LOST_COUNT_EN
    logic [LOST_W-1:0]     r_lost;
    logic [NUM_EVENTS-1:0] w_coal;
    logic [5:0]            w_lost_inc;
    logic [LOST_W:0]       w_lost_sum;

    // An edge on a bit that is pending and not being cleared this cycle is absorbed.
    assign w_coal = w_edge & r_pending & ~w_clr;

    always_comb begin
        w_lost_inc = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            w_lost_inc = w_lost_inc + 6'(w_coal[i]);
        end
    end

    assign w_lost_sum = {1'b0, r_lost} + (LOST_W + 1)'(w_lost_inc);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_lost <= '0;
        end else if (w_wr && w_idx == REG_LOST) begin
            r_lost <= '0;
        end else if (w_lost_sum[LOST_W]) begin
            r_lost <= '1;
        end else begin
            r_lost <= w_lost_sum[LOST_W-1:0];
        end
    end
`endif

    always_comb begin
        PRDATA = '0;
        if (w_rd) begin
            case (w_idx)
                REG_PENDING: PRDATA = 32'(r_pending);
                REG_MASK:    PRDATA = 32'(r_mask);
                REG_ID:      PRDATA = {w_vld, 26'd0, w_id};
`ifdef IRQ_LOST_COUNT_EN
                REG_LOST:    PRDATA = 32'(r_lost);
`endif
                default:     PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Randomised and directed bench for apb_irq_ctrl against a per-bit behavioural model.
module tb_apb_irq_ctrl;

    localparam int        NUM   = 8;
    localparam bit [31:0] LMASK = 32'h0000_00FF;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [7:0]  event_i = '0;
    logic        irq_ack_i = 1'b0;
    logic [4:0]  irq_ack_id_i = '0;
    logic        irq_o;
    logic [4:0]  irq_id_o;

    bit [31:0] m_pend, m_mask, m_prev;
    bit        m_fresh;
    int        m_lost;
    int        n_cmp = 0;
    int        n_fail = 0;

    apb_irq_ctrl #(.APB_ADDR_WIDTH(12), .NUM_EVENTS(NUM)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .event_i(event_i), .irq_ack_i(irq_ack_i), .irq_ack_id_i(irq_ack_id_i),
        .irq_o(irq_o), .irq_id_o(irq_id_o)
    );

    always #5 HCLK = ~HCLK;

    function automatic bit exp_irq();
        return |(m_pend & m_mask);
    endfunction

    function automatic bit [4:0] exp_id();
        bit [4:0] id = '0;
        for (int b = NUM - 1; b >= 0; b--) if (m_pend[b] && m_mask[b]) id = 5'(b);
        return id;
    endfunction

    function automatic bit [31:0] exp_rd(input int idx);
        case (idx)
            0: return m_pend;
            1: return m_mask;
            3: return {exp_irq(), 26'd0, exp_id()};
`ifdef IRQ_LOST_COUNT_EN
            4: return 32'(m_lost);
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock: evaluate the model on the inputs currently driven, then commit at the edge.
    task automatic tick();
        bit [31:0] np, nm, nprev;
        int        nl, idx;
        bit        nf, wr;
        wr  = PSEL && PENABLE && PWRITE;
        idx = int'(PADDR[4:2]);
        np = '0; nm = '0; nprev = '0; nl = 0; nf = 1'b1;
        if (!HRESET) begin
            np = m_pend; nm = m_mask; nl = m_lost; nf = 1'b0;
            for (int b = 0; b < NUM; b++) begin
                bit rise, setw, clr;
                rise = event_i[b] && !m_prev[b] && !m_fresh;
                setw = wr && idx == 2 && PWDATA[b];
                clr  = (irq_ack_i && int'(irq_ack_id_i) == b) || (wr && idx == 0 && PWDATA[b]);
                if (rise && m_pend[b] && !clr) nl++;
                if (rise || setw) np[b] = 1'b1;
                else if (clr)     np[b] = 1'b0;
                nprev[b] = event_i[b];
            end
            if (nl > 65535) nl = 65535;
            if (wr && idx == 1) nm = PWDATA & LMASK;
            if (wr && idx == 4) nl = 0;
        end
        @(posedge HCLK);
        m_pend = np; m_mask = nm; m_prev = nprev; m_lost = nl; m_fresh = nf;
        #1;
    endtask

    task automatic apb_idle();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_write(input int idx, input bit [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 12'(idx * 4); PWDATA = d;
        tick();
        PENABLE = 1'b1;
        tick();
        apb_idle();
    endtask

    task automatic apb_read(input int idx, output bit [31:0] got, output bit [31:0] exp);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 12'(idx * 4);
        tick();
        PENABLE = 1'b1;
        #1;
        got = PRDATA;
        exp = exp_rd(idx);
        tick();
        apb_idle();
    endtask

    task automatic pulse(input bit [7:0] m);
        event_i = m;
        tick();
        event_i = '0;
    endtask

    task automatic test_reset();
        bit [31:0] g, e;
        HRESET = 1'b1;
        repeat (3) tick();
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq_o); end
        n_cmp++; if (irq_id_o !== 5'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", irq_id_o); end
        n_cmp++; if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin n_fail++; $display("FAIL reset_pready_pslverr: got %b/%b want 1/0", PREADY, PSLVERR); end
        HRESET = 1'b0;
        tick();
        apb_read(0, g, e);
        n_cmp++; if (g !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", g); end
        apb_read(1, g, e);
        n_cmp++; if (g !== 32'h0) begin n_fail++; $display("FAIL reset_mask: got %h want 0", g); end
    endtask

    task automatic test_edge();
        bit [31:0] g, e;
        apb_write(1, 32'h1);
        pulse(8'h01);
        n_cmp++; if (irq_o !== 1'b1 || irq_id_o !== 5'd0) begin n_fail++; $display("FAIL edge_irq: got %b/%0d want 1/0", irq_o, irq_id_o); end
        apb_read(0, g, e);
        n_cmp++; if (g !== 32'h1 || g !== e) begin n_fail++; $display("FAIL edge_pending: got %h want 1 (model %h)", g, e); end
    endtask

    task automatic test_priority();
        apb_write(1, 32'hFF);
        apb_write(0, 32'hFF);
        pulse(8'h28);
        n_cmp++; if (irq_o !== 1'b1 || irq_id_o !== 5'd3) begin n_fail++; $display("FAIL prio_first: got %b/%0d want 1/3", irq_o, irq_id_o); end
        irq_ack_i = 1'b1; irq_ack_id_i = 5'd3;
        tick();
        irq_ack_i = 1'b0;
        n_cmp++; if (irq_o !== 1'b1 || irq_id_o !== 5'd5) begin n_fail++; $display("FAIL prio_second: got %b/%0d want 1/5", irq_o, irq_id_o); end
        irq_ack_i = 1'b1; irq_ack_id_i = 5'd5;
        tick();
        irq_ack_i = 1'b0;
        n_cmp++; if (irq_o !== 1'b0 || irq_id_o !== 5'd0) begin n_fail++; $display("FAIL prio_done: got %b/%0d want 0/0", irq_o, irq_id_o); end
    endtask

    task automatic test_mask();
        bit [31:0] g, e;
        apb_write(1, 32'h0);
        apb_write(0, 32'hFF);
        pulse(8'h04);
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL mask_irq_off: got %b want 0", irq_o); end
        apb_read(0, g, e);
        n_cmp++; if (g !== 32'h4) begin n_fail++; $display("FAIL mask_pending: got %h want 4", g); end
        apb_write(1, 32'h4);
        n_cmp++; if (irq_o !== 1'b1 || irq_id_o !== 5'd2) begin n_fail++; $display("FAIL mask_enable: got %b/%0d want 1/2", irq_o, irq_id_o); end
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 12'h004;
        #1;
        n_cmp++; if (PRDATA !== 32'h0) begin n_fail++; $display("FAIL prdata_setup_phase: got %h want 0", PRDATA); end
        apb_idle();
        apb_write(1, 32'h0);
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL mask_clear_irq: got %b want 0", irq_o); end
        apb_read(0, g, e);
        n_cmp++; if (g !== 32'h4) begin n_fail++; $display("FAIL mask_retain_pending: got %h want 4", g); end
    endtask

    task automatic test_collision();
        bit [31:0] g, e;
        apb_write(0, 32'hFF);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 12'h000; PWDATA = 32'h2;
        tick();
        PENABLE = 1'b1; event_i = 8'h02;
        tick();
        apb_idle(); event_i = '0;
        apb_read(0, g, e);
        n_cmp++; if (g !== 32'h2) begin n_fail++; $display("FAIL collide_w1c: got %h want 2", g); end
        irq_ack_i = 1'b1; irq_ack_id_i = 5'd1; event_i = 8'h02;
        tick();
        irq_ack_i = 1'b0; event_i = '0;
        apb_read(0, g, e);
        n_cmp++; if (g !== 32'h2) begin n_fail++; $display("FAIL collide_ack: got %h want 2", g); end
    endtask

    task automatic test_hold_merge();
        bit [31:0] g, e;
        apb_write(0, 32'hFF);
        apb_write(1, 32'hFF);
        event_i = 8'h40;
        tick();
        irq_ack_i = 1'b1; irq_ack_id_i = 5'd6;
        tick();
        irq_ack_i = 1'b0;
        repeat (2) tick();
        event_i = '0;
        tick();
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL hold_irq: got %b want 0", irq_o); end
        apb_read(0, g, e);
        n_cmp++; if (g !== 32'h0) begin n_fail++; $display("FAIL hold_pending: got %h want 0", g); end
    endtask

    task automatic test_ack_oob();
        bit [31:0] g, e;
        apb_write(0, 32'hFF);
        pulse(8'h01);
        irq_ack_i = 1'b1; irq_ack_id_i = 5'd8;
        tick();
        irq_ack_id_i = 5'd24;
        tick();
        irq_ack_i = 1'b0;
        n_cmp++; if (irq_o !== 1'b1 || irq_id_o !== 5'd0) begin n_fail++; $display("FAIL ack_oob_irq: got %b/%0d want 1/0", irq_o, irq_id_o); end
        apb_read(0, g, e);
        n_cmp++; if (g !== 32'h1) begin n_fail++; $display("FAIL ack_oob_pending: got %h want 1", g); end
    endtask

    task automatic test_regmap();
        bit [31:0] g, e;
        apb_write(1, 32'hFFFF_FFFF);
        apb_read(1, g, e);
        n_cmp++; if (g !== 32'hFF) begin n_fail++; $display("FAIL regmap_mask_width: got %h want ff", g); end
        apb_write(0, 32'hFF);
        apb_write(2, 32'hFFFF_FF81);
        apb_read(0, g, e);
        n_cmp++; if (g !== 32'h81) begin n_fail++; $display("FAIL regmap_set: got %h want 81", g); end
        apb_read(2, g, e);
        n_cmp++; if (g !== 32'h0) begin n_fail++; $display("FAIL regmap_set_reads0: got %h want 0", g); end
        apb_read(3, g, e);
        n_cmp++; if (g !== 32'h8000_0000) begin n_fail++; $display("FAIL regmap_id: got %h want 80000000", g); end
        for (int i = 5; i < 8; i++) begin
            apb_write(i, $urandom);
            apb_read(i, g, e);
            n_cmp++; if (g !== 32'h0) begin n_fail++; $display("FAIL regmap_idx%0d: got %h want 0", i, g); end
        end
        apb_read(0, g, e);
        n_cmp++; if (g !== 32'h81) begin n_fail++; $display("FAIL regmap_pending_kept: got %h want 81", g); end
    endtask

    task automatic test_lost();
        bit [31:0] g, e;
        apb_write(0, 32'hFF);
        apb_write(4, 32'h0);
        repeat (3) begin
            pulse(8'h10);
            tick();
        end
        apb_read(4, g, e);
`ifdef IRQ_LOST_COUNT_EN
        n_cmp++; if (g !== 32'h2) begin n_fail++; $display("FAIL lost_count: got %h want 2", g); end
`else
        n_cmp++; if (g !== 32'h0) begin n_fail++; $display("FAIL lost_absent: got %h want 0", g); end
`endif
        apb_write(4, 32'h1234);
        apb_read(4, g, e);
        n_cmp++; if (g !== 32'h0) begin n_fail++; $display("FAIL lost_clear: got %h want 0", g); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            event_i      = 8'($urandom & $urandom & $urandom);
            irq_ack_i    = ($urandom_range(0, 3) == 0);
            irq_ack_id_i = 5'($urandom_range(0, 11));
            if (PSEL && !PENABLE) PENABLE = 1'b1;
            else if (PSEL) apb_idle();
            else if ($urandom_range(0, 4) == 0) begin
                PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'($urandom_range(0, 1));
                PADDR = 12'($urandom); PWDATA = $urandom;
            end
            #1;
            n_cmp++; if (irq_o !== exp_irq() || irq_id_o !== exp_id()) begin
                n_fail++; $display("FAIL rand_irq c%0d: got %b/%0d want %b/%0d", c, irq_o, irq_id_o, exp_irq(), exp_id());
            end
            n_cmp++;
            if (PSEL && PENABLE && !PWRITE) begin
                if (PRDATA !== exp_rd(int'(PADDR[4:2]))) begin
                    n_fail++; $display("FAIL rand_read c%0d idx%0d: got %h want %h", c, PADDR[4:2], PRDATA, exp_rd(int'(PADDR[4:2])));
                end
            end else if (PRDATA !== 32'h0) begin
                n_fail++; $display("FAIL rand_prdata_idle c%0d: got %h want 0", c, PRDATA);
            end
            tick();
        end
        apb_idle(); event_i = '0; irq_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit [31:0] g, e;
        apb_write(2, 32'hFF);
        apb_write(1, 32'hFF);
        n_cmp++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got %b want 1", irq_o); end
        HRESET = 1'b1; event_i = 8'h01;
        tick();
        n_cmp++; if (irq_o !== 1'b0 || irq_id_o !== 5'd0) begin n_fail++; $display("FAIL rst_mid_irq: got %b/%0d want 0/0", irq_o, irq_id_o); end
        tick();
        HRESET = 1'b0;
        repeat (3) tick();
        apb_read(0, g, e);
        n_cmp++; if (g !== 32'h0) begin n_fail++; $display("FAIL rst_mid_pending: got %h want 0", g); end
        apb_read(1, g, e);
        n_cmp++; if (g !== 32'h0) begin n_fail++; $display("FAIL rst_mid_mask: got %h want 0", g); end
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_irq_after: got %b want 0", irq_o); end
        event_i = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_edge();
        test_priority();
        test_mask();
        test_collision();
        test_hold_merge();
        test_ack_oob();
        test_regmap();
        test_lost();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
